// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - opcode constants (IR[31:26]) for the supported instructions
//   - ALU op class driven to alu_control as {alu_op1, alu_op0}
//   - ALU operand B and PC source select encodings
//   - controller state encoding (also exported on the debug state port)
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback over one shared
// memory port and one ALU, stalls on mem_ready, counts retired instructions.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   opcode, zero          IR[31:26] (used in DECODE), ALU zero (used in BRANCH)
//   mem_ready             memory completes the current access this cycle
//   mem_read/mem_write/iord, ir_write, reg_write/reg_dst/mem_to_reg,
//   alu_src_a/alu_src_b, alu_op1/alu_op0, pc_src/pc_en   datapath controls
//   illegal               one-cycle pulse on an unsupported opcode
//   state, retired        debug state encoding, retired-instruction count
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op1,
  output logic             alu_op0,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  // lw/sw choice is captured in DECODE so MEMADR does not look at opcode again
  logic             is_sw_q;
  logic             retire;

  logic mem_read_r, mem_write_r, ir_write_r, reg_write_r, pc_en_r, illegal_r;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state_q == S_DECODE) is_sw_q <= (opcode == OP_SW);
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    mem_read_r  = 1'b0;
    mem_write_r = 1'b0;
    ir_write_r  = 1'b0;
    reg_write_r = 1'b0;
    pc_en_r     = 1'b0;
    illegal_r   = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    aluop       = ALUOP_ADD;
    pc_src      = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read_r = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_r = mem_ready;
        pc_en_r    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal_r = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_r = 1'b1;
        iord       = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_r = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_MEMWR: begin
        mem_write_r = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_r = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en_r   = zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en_r = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_r = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      default: state_d = S_FETCH; // encodings 12-15: recover, no strobes
    endcase
  end

  // Strobes are suppressed during reset so a write never lands in the reset cycle
  assign mem_read  = mem_read_r  & rst_n;
  assign mem_write = mem_write_r & rst_n;
  assign ir_write  = ir_write_r  & rst_n;
  assign reg_write = reg_write_r & rst_n;
  assign pc_en     = pc_en_r     & rst_n;
  assign illegal   = illegal_r   & rst_n;

  assign alu_op1 = aluop[1];
  assign alu_op0 = aluop[0];
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench: a table of per-cycle vectors {inputs, expected outputs}
// followed by hand-written stall and reset sequences. A second instance
// with a 2-bit counter shares the inputs and exercises counter wrap.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode;

  logic mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, alu_op1, alu_op0, pc_en, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;
  logic [15:0] retired;

  logic mem_read2, mem_write2, iord2, ir_write2, reg_write2, reg_dst2, mem_to_reg2;
  logic alu_src_a2, alu_op12, alu_op02, pc_en2, illegal2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [3:0] state2;
  logic [1:0] retired2;

  mips_multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1), .alu_op0(alu_op0),
    .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal), .state(state), .retired(retired)
  );

  mips_multicycle_control #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read2), .mem_write(mem_write2), .iord(iord2), .ir_write(ir_write2),
    .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op1(alu_op12), .alu_op0(alu_op02),
    .pc_src(pc_src2), .pc_en(pc_en2), .illegal(illegal2), .state(state2), .retired(retired2)
  );

  // {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b[1:0], aluop[1:0], pc_src[1:0], pc_en, illegal}
  logic [15:0] ctl;
  assign ctl = {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op1, alu_op0, pc_src, pc_en, illegal};

  //                                  rd wr io ir rw rd m2 sa sb  op pc pe il
  localparam logic [15:0] C_RST     = 16'b0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [15:0] C_FETCH   = 16'b1_0_0_1_0_0_0_0_01_00_00_1_0;
  localparam logic [15:0] C_FETCHS  = 16'b1_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [15:0] C_DEC     = 16'b0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [15:0] C_ILL     = 16'b0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [15:0] C_MEMADR  = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [15:0] C_MEMRD   = 16'b1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [15:0] C_MEMWR   = 16'b0_1_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] C_MEMWRR  = 16'b0_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] C_EXEC    = 16'b0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [15:0] C_ALUWB   = 16'b0_0_0_0_1_1_0_0_00_00_00_0_0;
  localparam logic [15:0] C_BR1     = 16'b0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [15:0] C_BR0     = 16'b0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [15:0] C_JUMP    = 16'b0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [15:0] C_ADDIEX  = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [15:0] C_ADDIWB  = 16'b0_0_0_0_1_0_0_0_00_00_00_0_0;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctl;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] c, input logic [15:0] ret);
    vec_t v;
    v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy;
    v.exp_state = st; v.exp_ctl = c; v.exp_ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, compare #1 later (well before the next rising edge)
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst_n; opcode = v.op; zero = v.zero; mem_ready = v.rdy;
    #1;
    chk($sformatf("v%0d.state", idx), {12'd0, state}, {12'd0, v.exp_state});
    chk($sformatf("v%0d.ctl", idx), ctl, v.exp_ctl);
    chk($sformatf("v%0d.retired", idx), retired, v.exp_ret);
    chk($sformatf("v%0d.retired2", idx), {14'd0, retired2}, {14'd0, v.exp_ret[1:0]});
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  initial begin
    rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b1;

    //   rst op    z  rdy st  ctl        retired
    add(0, RT,   0, 1, 0,  C_RST,     0);
    add(0, RT,   0, 1, 0,  C_RST,     0);
    add(1, RT,   0, 1, 0,  C_FETCH,   0);
    add(1, LW,   0, 1, 1,  C_DEC,     0);
    add(1, SW,   0, 1, 2,  C_MEMADR,  0);  // opcode change after DECODE ignored
    add(1, SW,   0, 0, 3,  C_MEMRD,   0);
    add(1, SW,   0, 0, 3,  C_MEMRD,   0);
    add(1, SW,   0, 1, 3,  C_MEMRD,   0);
    add(1, SW,   0, 1, 4,  C_MEMWB,   0);
    add(1, RT,   0, 1, 0,  C_FETCH,   1);
    add(1, RT,   0, 1, 1,  C_DEC,     1);
    add(1, BAD,  0, 0, 6,  C_EXEC,    1);  // mem_ready ignored outside memory states
    add(1, BAD,  0, 0, 7,  C_ALUWB,   1);
    add(1, RT,   0, 1, 0,  C_FETCH,   2);
    add(1, BEQ,  0, 1, 1,  C_DEC,     2);
    add(1, BEQ,  1, 1, 8,  C_BR1,     2);
    add(1, BEQ,  0, 1, 0,  C_FETCH,   3);
    add(1, BEQ,  0, 1, 1,  C_DEC,     3);
    add(1, BEQ,  0, 1, 8,  C_BR0,     3);
    add(1, RT,   0, 1, 0,  C_FETCH,   4);  // retired2 wraps to 0 here
    add(1, BAD,  0, 1, 1,  C_ILL,     4);
    add(1, JMP,  0, 1, 0,  C_FETCH,   4);  // illegal did not retire
    add(1, JMP,  0, 1, 1,  C_DEC,     4);
    add(1, RT,   0, 1, 9,  C_JUMP,    4);
    add(1, RT,   0, 1, 0,  C_FETCH,   5);
    add(1, ADDI, 0, 1, 1,  C_DEC,     5);
    add(1, RT,   0, 1, 10, C_ADDIEX,  5);
    add(1, RT,   0, 1, 11, C_ADDIWB,  5);
    add(1, RT,   0, 0, 0,  C_FETCHS,  6);
    add(1, RT,   0, 1, 0,  C_FETCH,   6);
    add(1, SW,   0, 1, 1,  C_DEC,     6);
    add(1, LW,   0, 1, 2,  C_MEMADR,  6);
    add(1, LW,   0, 0, 5,  C_MEMWR,   6);
    add(1, LW,   0, 1, 5,  C_MEMWR,   6);
    add(1, RT,   0, 1, 0,  C_FETCH,   7);
    add(1, SW,   0, 1, 1,  C_DEC,     7);
    add(1, RT,   0, 1, 2,  C_MEMADR,  7);
    add(1, RT,   0, 0, 5,  C_MEMWR,   7);
    add(0, RT,   0, 1, 5,  C_MEMWRR,  7);  // reset mid-MEMWR: no write strobe
    add(1, RT,   0, 0, 0,  C_FETCHS,  0);  // counter cleared, no partial retire

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: long MEMRD stall, strobes and iord held every cycle
    apply('{1'b1, RT, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd0}, 100);
    apply('{1'b1, LW, 1'b0, 1'b1, 4'd1, C_DEC,   16'd0}, 101);
    apply('{1'b1, LW, 1'b0, 1'b1, 4'd2, C_MEMADR,16'd0}, 102);
    for (int k = 0; k < 4; k++)
      apply('{1'b1, BAD, 1'b1, 1'b0, 4'd3, C_MEMRD, 16'd0}, 110 + k);
    // Reset during the stall: state returns to FETCH, nothing retired
    apply('{1'b0, LW, 1'b0, 1'b1, 4'd3, C_MEMRD & ~16'h8000, 16'd0}, 120);
    apply('{1'b1, LW, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd0}, 121);
    apply('{1'b1, RT, 1'b0, 1'b1, 4'd1, C_DEC,   16'd0}, 122);
    apply('{1'b1, RT, 1'b0, 1'b1, 4'd6, C_EXEC,  16'd0}, 123);
    apply('{1'b1, RT, 1'b0, 1'b1, 4'd7, C_ALUWB, 16'd0}, 124);
    apply('{1'b1, RT, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd1}, 125);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath in mips_stub. It sequences instruction fetch, decode, execute, memory access and writeback over a single shared memory port and a single ALU. It drives alu_op1/alu_op0 into alu_control, which derives the 3-bit ALU op from those bits and funct F. It also waits on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag, valid during BRANCH
mem_ready  in  1  memory completes the current read/write in this cycle
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  load instruction register
reg_write  out  1  register file write enable
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
alu_op1  out  1  ALU op class, high bit
alu_op0  out  1  ALU op class, low bit
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en  out  1  PC load enable
illegal  out  1  unsupported opcode seen (one-cycle pulse)
state  out  4  current state encoding, for debug
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: when rst_n is sampled low, state <= FETCH and retired <= 0. While rst_n is low, all strobes are forced 0: mem_read, mem_write, ir_write, reg_write, pc_en, illegal.
- Outputs are Moore-decoded from state. The exceptions are ir_write, pc_en and the state-advance conditions, which also depend on mem_ready and zero (same cycle, combinational).
- ALU op class {alu_op1, alu_op0}: 00 = add, 01 = sub, 10 = use funct. The value 11 is never driven.
- States, with the non-listed outputs at 0:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00. ir_write = pc_en = mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, aluop=00. Next state by opcode:
    - 100011 (lw) or 101011 (sw): MEMADR
    - 000000 (R-type): EXECUTE
    - 000100 (beq): BRANCH
    - 000010 (j): JUMP
    - 001000 (addi): ADDIEX
    - any other opcode: illegal=1 for this cycle, go to FETCH, no retire.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH; retire.
  - MEMWR(5): mem_write=1, iord=1. Wait for mem_ready, then go to FETCH; retire on the exit cycle.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, aluop=10. Go to ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH; retire.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01, pc_en=zero. Go to FETCH; retire.
  - JUMP(9): pc_src=10, pc_en=1. Go to FETCH; retire.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, aluop=00. Go to ADDIWB.
  - ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH; retire.
- Encodings 12-15 are unreachable; if entered, go to FETCH with all strobes 0.
- retired increments by 1 on the clock edge that leaves a retire state into FETCH. It wraps from 2^CNT_W-1 to 0. It is not incremented on an illegal opcode.
- Latency with mem_ready tied high, FETCH through last state:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each mem_ready-low cycle adds one cycle. During the stall, strobes and address select are held stable.
- Reset asserted mid-instruction (including mid-stall): the next state is FETCH, no partial retire is counted, and no write strobe is issued in the reset cycle.
- mem_ready is ignored in states without a memory access.
- opcode is only sampled in DECODE. Changes to it in other states have no effect.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALU op class constants ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10
  - state encoding constants S_FETCH..S_ADDIWB
  - alu_src_b and pc_src select constants
- No sub-module: next-state logic, output decode and counter are all in one module.

Test Plan:
- Reset, then check outputs with mem_ready=1: hold rst_n=0 for 2 clocks → state=0, retired=0, all strobes 0. Release → mem_read=1, ir_write=1, pc_en=1 in the first cycle.
- lw with a 2-cycle stall (opcode=100011, mem_ready=0 for 2 cycles in MEMRD) → state sequence 0,1,2,3,3,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. retired goes 0→1.
- R-type with F=6'b100000 → state sequence 0,1,6,7,0. {alu_op1,alu_op0}=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
- beq: first with zero=1 in BRANCH → pc_en=1, pc_src=01, aluop=01. Repeat with zero=0 → pc_en=0. retired increments both times.
- Illegal opcode 111111 → illegal=1 for exactly one cycle in state 1, then state=0, retired unchanged.
- Reset mid-MEMWR stall: drop rst_n while in state 5 with mem_ready=0 → next state=0, mem_write=0 in the reset cycle, no retire. Separately, with CNT_W=2, retire 4 instructions → retired wraps to 0.
